// File: rtl/bellek_hakem.sv
// bellek_hakem: round-robin arbiter and single-transaction sequencer that lets
// instruction fetch (g_) and load/store (v_) share one variable-latency memory.
// Optional wait timeout: define BELLEK_HAKEM_ZAMAN_ASIMI_EN to enable it.
module bellek_hakem #(
  parameter int unsigned ADRES_W     = 32,
  parameter int unsigned VERI_W      = 32,
  parameter int unsigned ZAMAN_ASIMI = 16
) (
  input  logic                  saat,
  input  logic                  reset,
  // instruction fetch requester
  input  logic                  g_istek,
  input  logic [ADRES_W-1:0]    g_adres,
  output logic                  g_kabul,
  output logic                  g_gecerli,
  output logic [VERI_W-1:0]     g_veri,
  // load/store requester
  input  logic                  v_istek,
  input  logic                  v_yaz,
  input  logic [ADRES_W-1:0]    v_adres,
  input  logic [VERI_W-1:0]     v_yveri,
  input  logic [VERI_W/8-1:0]   v_bayt,
  output logic                  v_kabul,
  output logic                  v_gecerli,
  output logic [VERI_W-1:0]     v_veri,
  // memory port
  output logic                  b_istek,
  output logic                  b_yaz,
  output logic [ADRES_W-1:0]    b_adres,
  output logic [VERI_W-1:0]     b_yveri,
  output logic [VERI_W/8-1:0]   b_bayt,
  input  logic                  b_hazir,
  input  logic [VERI_W-1:0]     b_overi,
  output logic                  hata
);

  localparam int unsigned BAYT_W   = VERI_W / 8;
  localparam int unsigned SAYAC_W  = 8;
  localparam logic        SON_G    = 1'b0;
  localparam logic        SON_V    = 1'b1;

  typedef enum logic {BOS = 1'b0, BEKLE = 1'b1} durum_t;

  // Reject timeout values the 8-bit wait counter cannot represent.
  if (ZAMAN_ASIMI < 2 || ZAMAN_ASIMI > 255) begin : g_parametre_kontrol
    $error("bellek_hakem: ZAMAN_ASIMI must be in 2..255");
  end

  durum_t               durum_q, durum_d;
  logic                 son_q, son_d;
  logic                 b_istek_q, b_istek_d;
  logic                 b_yaz_q, b_yaz_d;
  logic [ADRES_W-1:0]   b_adres_q, b_adres_d;
  logic [VERI_W-1:0]    b_yveri_q, b_yveri_d;
  logic [BAYT_W-1:0]    b_bayt_q, b_bayt_d;
  logic                 g_kabul_q, g_kabul_d;
  logic                 g_gecerli_q, g_gecerli_d;
  logic [VERI_W-1:0]    g_veri_q, g_veri_d;
  logic                 v_kabul_q, v_kabul_d;
  logic                 v_gecerli_q, v_gecerli_d;
  logic [VERI_W-1:0]    v_veri_q, v_veri_d;

  logic                 g_kazanir_c;
  logic                 v_kazanir_c;
  logic                 zaman_doldu_c;

`ifdef BELLEK_HAKEM_ZAMAN_ASIMI_EN
  logic [SAYAC_W-1:0]   sayac_q, sayac_d;
  logic                 hata_q, hata_d;

  // Timeout fires on the wait edge where the counter reaches its last value.
  assign zaman_doldu_c = !b_hazir && (sayac_q == SAYAC_W'(ZAMAN_ASIMI - 1));
  assign hata          = hata_q;
`else
  assign zaman_doldu_c = 1'b0;
  assign hata          = 1'b0;
`endif

  // Arbitration: a lone requester wins; on contention the one not granted last wins.
  assign g_kazanir_c = g_istek && (!v_istek || (son_q == SON_V));
  assign v_kazanir_c = v_istek && !g_kazanir_c;

  // State register.
  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      durum_q <= BOS;
    end else begin
      durum_q <= durum_d;
    end
  end

  // Next-state logic.
  always_comb begin
    durum_d = durum_q;
    case (durum_q)
      BOS:     if (g_istek || v_istek)      durum_d = BEKLE;
      BEKLE:   if (b_hazir || zaman_doldu_c) durum_d = BOS;
      default: durum_d = BOS;
    endcase
  end

  // Output/datapath next values: grant capture, completion and timeout handling.
  always_comb begin
    son_d       = son_q;
    b_istek_d   = b_istek_q;
    b_yaz_d     = b_yaz_q;
    b_adres_d   = b_adres_q;
    b_yveri_d   = b_yveri_q;
    b_bayt_d    = b_bayt_q;
    g_kabul_d   = 1'b0;
    g_gecerli_d = 1'b0;
    g_veri_d    = g_veri_q;
    v_kabul_d   = 1'b0;
    v_gecerli_d = 1'b0;
    v_veri_d    = v_veri_q;
`ifdef BELLEK_HAKEM_ZAMAN_ASIMI_EN
    sayac_d     = sayac_q;
    hata_d      = 1'b0;
`endif
    case (durum_q)
      BOS: begin
        if (g_kazanir_c) begin
          b_istek_d = 1'b1;
          b_yaz_d   = 1'b0;
          b_adres_d = g_adres;
          b_yveri_d = '0;
          b_bayt_d  = '1;
          g_kabul_d = 1'b1;
          son_d     = SON_G;
`ifdef BELLEK_HAKEM_ZAMAN_ASIMI_EN
          sayac_d   = '0;
`endif
        end else if (v_kazanir_c) begin
          b_istek_d = 1'b1;
          b_yaz_d   = v_yaz;
          b_adres_d = v_adres;
          b_yveri_d = v_yveri;
          b_bayt_d  = v_bayt;
          v_kabul_d = 1'b1;
          son_d     = SON_V;
`ifdef BELLEK_HAKEM_ZAMAN_ASIMI_EN
          sayac_d   = '0;
`endif
        end
      end
      BEKLE: begin
        if (b_hazir) begin
          b_istek_d = 1'b0;
          if (son_q == SON_G) begin
            g_gecerli_d = 1'b1;
            if (!b_yaz_q) g_veri_d = b_overi;
          end else begin
            v_gecerli_d = 1'b1;
            if (!b_yaz_q) v_veri_d = b_overi;
          end
        end
`ifdef BELLEK_HAKEM_ZAMAN_ASIMI_EN
        else if (zaman_doldu_c) begin
          b_istek_d = 1'b0;
          hata_d    = 1'b1;
          if (son_q == SON_G) begin
            g_gecerli_d = 1'b1;
            g_veri_d    = '0;
          end else begin
            v_gecerli_d = 1'b1;
            v_veri_d    = '0;
          end
        end else begin
          sayac_d = sayac_q + SAYAC_W'(1);
        end
`endif
      end
      default: begin
        b_istek_d = 1'b0;
      end
    endcase
  end

  // Registered outputs and arbitration history; reset drops any transaction in flight.
  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      son_q       <= SON_V;
      b_istek_q   <= 1'b0;
      b_yaz_q     <= 1'b0;
      b_adres_q   <= '0;
      b_yveri_q   <= '0;
      b_bayt_q    <= '0;
      g_kabul_q   <= 1'b0;
      g_gecerli_q <= 1'b0;
      g_veri_q    <= '0;
      v_kabul_q   <= 1'b0;
      v_gecerli_q <= 1'b0;
      v_veri_q    <= '0;
`ifdef BELLEK_HAKEM_ZAMAN_ASIMI_EN
      sayac_q     <= '0;
      hata_q      <= 1'b0;
`endif
    end else begin
      son_q       <= son_d;
      b_istek_q   <= b_istek_d;
      b_yaz_q     <= b_yaz_d;
      b_adres_q   <= b_adres_d;
      b_yveri_q   <= b_yveri_d;
      b_bayt_q    <= b_bayt_d;
      g_kabul_q   <= g_kabul_d;
      g_gecerli_q <= g_gecerli_d;
      g_veri_q    <= g_veri_d;
      v_kabul_q   <= v_kabul_d;
      v_gecerli_q <= v_gecerli_d;
      v_veri_q    <= v_veri_d;
`ifdef BELLEK_HAKEM_ZAMAN_ASIMI_EN
      sayac_q     <= sayac_d;
      hata_q      <= hata_d;
`endif
    end
  end

  assign b_istek   = b_istek_q;
  assign b_yaz     = b_yaz_q;
  assign b_adres   = b_adres_q;
  assign b_yveri   = b_yveri_q;
  assign b_bayt    = b_bayt_q;
  assign g_kabul   = g_kabul_q;
  assign g_gecerli = g_gecerli_q;
  assign g_veri    = g_veri_q;
  assign v_kabul   = v_kabul_q;
  assign v_gecerli = v_gecerli_q;
  assign v_veri    = v_veri_q;

endmodule

// File: tb/tb_bellek_hakem.sv
// Directed testbench for bellek_hakem (timeout check adapts to BELLEK_HAKEM_ZAMAN_ASIMI_EN).
module tb_bellek_hakem;

  localparam int unsigned ADRES_W = 32;
  localparam int unsigned VERI_W  = 32;

  logic                saat = 1'b0;
  logic                reset;
  logic                g_istek, g_kabul, g_gecerli;
  logic [ADRES_W-1:0]  g_adres;
  logic [VERI_W-1:0]   g_veri;
  logic                v_istek, v_yaz, v_kabul, v_gecerli;
  logic [ADRES_W-1:0]  v_adres;
  logic [VERI_W-1:0]   v_yveri, v_veri;
  logic [3:0]          v_bayt;
  logic                b_istek, b_yaz, b_hazir, hata;
  logic [ADRES_W-1:0]  b_adres;
  logic [VERI_W-1:0]   b_yveri, b_overi;
  logic [3:0]          b_bayt;

  int hata_say    = 0;
  int kontrol_say = 0;

  always #5 saat = ~saat;

  bellek_hakem #(.ADRES_W(ADRES_W), .VERI_W(VERI_W), .ZAMAN_ASIMI(4)) dut (
    .saat(saat), .reset(reset),
    .g_istek(g_istek), .g_adres(g_adres), .g_kabul(g_kabul),
    .g_gecerli(g_gecerli), .g_veri(g_veri),
    .v_istek(v_istek), .v_yaz(v_yaz), .v_adres(v_adres), .v_yveri(v_yveri),
    .v_bayt(v_bayt), .v_kabul(v_kabul), .v_gecerli(v_gecerli), .v_veri(v_veri),
    .b_istek(b_istek), .b_yaz(b_yaz), .b_adres(b_adres), .b_yveri(b_yveri),
    .b_bayt(b_bayt), .b_hazir(b_hazir), .b_overi(b_overi), .hata(hata)
  );

  // One clock: pass the active edge, then settle at the falling edge for sampling.
  task automatic adim();
    @(posedge saat);
    @(negedge saat);
  endtask

  task automatic test_reset();
    logic [138:0] hepsi;
    reset = 1'b0;
    g_istek = 1'b0; g_adres = '0;
    v_istek = 1'b0; v_yaz = 1'b0; v_adres = '0; v_yveri = '0; v_bayt = '0;
    b_hazir = 1'b0; b_overi = '0;
    @(negedge saat);
    @(negedge saat);
    hepsi = {b_istek, b_yaz, b_adres, b_yveri, b_bayt, g_kabul, g_gecerli, g_veri,
             v_kabul, v_gecerli, v_veri, hata};
    kontrol_say++;
    if (hepsi !== '0) begin
      hata_say++; $display("FAIL reset_outputs: got %h need 0", hepsi);
    end
    reset = 1'b1;
    @(negedge saat);
  endtask

  task automatic test_alternate();
    logic g;
    g_istek = 1'b1; g_adres = 32'h100;
    v_istek = 1'b1; v_yaz = 1'b0; v_adres = 32'h200; v_bayt = 4'h0;
    b_hazir = 1'b1;
    for (int t = 0; t < 4; t++) begin
      g = (t % 2 == 0);
      b_overi = 32'hA000_0000 + 32'(t);
      adim();
      kontrol_say++;
      if ({g_kabul, v_kabul, b_istek, g_gecerli, v_gecerli} !== {g, !g, 1'b1, 1'b0, 1'b0}) begin
        hata_say++; $display("FAIL alt_grant%0d: kabul g/v=%b%b b_istek=%b gecerli g/v=%b%b need g=%b",
                             t, g_kabul, v_kabul, b_istek, g_gecerli, v_gecerli, g);
      end
      kontrol_say++;
      if (b_adres !== (g ? 32'h100 : 32'h200)) begin
        hata_say++; $display("FAIL alt_adres%0d: got %h", t, b_adres);
      end
      if (t == 0) begin
        kontrol_say++;
        if ({b_yaz, b_bayt} !== 5'b0_1111) begin
          hata_say++; $display("FAIL alt_fetch_bayt: yaz=%b bayt=%h need 0/f", b_yaz, b_bayt);
        end
      end
      adim();
      kontrol_say++;
      if ({g_gecerli, v_gecerli, b_istek, g_kabul, v_kabul} !== {g, !g, 1'b0, 1'b0, 1'b0}) begin
        hata_say++; $display("FAIL alt_done%0d: gecerli g/v=%b%b b_istek=%b kabul g/v=%b%b need g=%b",
                             t, g_gecerli, v_gecerli, b_istek, g_kabul, v_kabul, g);
      end
      kontrol_say++;
      if ((g ? g_veri : v_veri) !== 32'hA000_0000 + 32'(t)) begin
        hata_say++; $display("FAIL alt_veri%0d: got %h need %h", t, (g ? g_veri : v_veri),
                             32'hA000_0000 + 32'(t));
      end
    end
    g_istek = 1'b0; v_istek = 1'b0; b_hazir = 1'b0;
    adim();
  endtask

  task automatic test_single_fetch();
    g_istek = 1'b1; g_adres = 32'h10;
    adim();
    kontrol_say++;
    if ({g_kabul, b_istek, b_yaz, b_bayt, b_adres} !== {1'b1, 1'b1, 1'b0, 4'hF, 32'h10}) begin
      hata_say++; $display("FAIL fetch_grant: kabul=%b b_istek=%b yaz=%b bayt=%h adres=%h",
                           g_kabul, b_istek, b_yaz, b_bayt, b_adres);
    end
    g_istek = 1'b0; b_hazir = 1'b1; b_overi = 32'h00A0_0513;
    adim();
    kontrol_say++;
    if ({g_gecerli, g_kabul, b_istek} !== 3'b100 || g_veri !== 32'h00A0_0513) begin
      hata_say++; $display("FAIL fetch_done: gecerli=%b kabul=%b b_istek=%b veri=%h need 1/0/0/00a00513",
                           g_gecerli, g_kabul, b_istek, g_veri);
    end
    kontrol_say++;
    if ({v_kabul, v_gecerli} !== 2'b00 || v_veri !== 32'hA000_0003) begin
      hata_say++; $display("FAIL fetch_v_quiet: kabul=%b gecerli=%b veri=%h need 0/0/a0000003",
                           v_kabul, v_gecerli, v_veri);
    end
    b_hazir = 1'b0;
    adim();
    kontrol_say++;
    if (g_gecerli !== 1'b0) begin
      hata_say++; $display("FAIL fetch_pulse_len: gecerli=%b need 0", g_gecerli);
    end
  endtask

  task automatic test_store();
    v_istek = 1'b1; v_yaz = 1'b1; v_adres = 32'h20; v_yveri = 32'hDEAD_BEEF; v_bayt = 4'hF;
    b_overi = 32'h5555_AAAA;
    adim();
    kontrol_say++;
    if (v_kabul !== 1'b1) begin
      hata_say++; $display("FAIL store_kabul: got %b need 1", v_kabul);
    end
    v_istek = 1'b0; v_yaz = 1'b0; v_adres = 32'hFFFF_0000; v_yveri = '0; v_bayt = '0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) adim();
      kontrol_say++;
      if ({b_istek, b_yaz, b_adres, b_yveri, b_bayt, v_gecerli} !==
          {1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF, 1'b0}) begin
        hata_say++; $display("FAIL store_hold%0d: istek=%b yaz=%b adres=%h yveri=%h bayt=%h gecerli=%b",
                             i, b_istek, b_yaz, b_adres, b_yveri, b_bayt, v_gecerli);
      end
    end
    b_hazir = 1'b1;
    adim();
    kontrol_say++;
    if ({v_gecerli, b_istek} !== 2'b10 || v_veri !== 32'hA000_0003) begin
      hata_say++; $display("FAIL store_done: gecerli=%b b_istek=%b veri=%h need 1/0/a0000003",
                           v_gecerli, b_istek, v_veri);
    end
    b_hazir = 1'b0;
    adim();
  endtask

  task automatic test_back_to_back();
    g_istek = 1'b1; g_adres = 32'h0; b_hazir = 1'b1; b_overi = 32'h1111_1111;
    adim();
    kontrol_say++;
    if ({g_kabul, b_adres} !== {1'b1, 32'h0}) begin
      hata_say++; $display("FAIL b2b_grant1: kabul=%b adres=%h need 1/0", g_kabul, b_adres);
    end
    g_adres = 32'h4;
    adim();
    kontrol_say++;
    if ({g_gecerli, g_kabul} !== 2'b10 || g_veri !== 32'h1111_1111) begin
      hata_say++; $display("FAIL b2b_done1: gecerli=%b kabul=%b veri=%h", g_gecerli, g_kabul, g_veri);
    end
    b_overi = 32'h2222_2222;
    adim();
    kontrol_say++;
    if ({g_kabul, b_istek, b_adres} !== {1'b1, 1'b1, 32'h4}) begin
      hata_say++; $display("FAIL b2b_grant2: kabul=%b istek=%b adres=%h need 1/1/4",
                           g_kabul, b_istek, b_adres);
    end
    g_istek = 1'b0;
    adim();
    kontrol_say++;
    if (g_gecerli !== 1'b1 || g_veri !== 32'h2222_2222) begin
      hata_say++; $display("FAIL b2b_done2: gecerli=%b veri=%h", g_gecerli, g_veri);
    end
    b_hazir = 1'b0;
    adim();
  endtask

  task automatic test_timeout();
    v_istek = 1'b1; v_yaz = 1'b0; v_adres = 32'h40; v_bayt = 4'h0;
    b_hazir = 1'b0;
    adim();
    kontrol_say++;
    if (v_kabul !== 1'b1) begin
      hata_say++; $display("FAIL tmo_kabul: got %b need 1", v_kabul);
    end
    v_istek = 1'b0;
`ifdef BELLEK_HAKEM_ZAMAN_ASIMI_EN
    for (int i = 1; i < 4; i++) begin
      adim();
      kontrol_say++;
      if ({v_gecerli, hata, b_istek} !== 3'b001) begin
        hata_say++; $display("FAIL tmo_wait%0d: gecerli=%b hata=%b istek=%b need 0/0/1",
                             i, v_gecerli, hata, b_istek);
      end
    end
    adim();
    kontrol_say++;
    if ({v_gecerli, hata, b_istek} !== 3'b110 || v_veri !== 32'h0) begin
      hata_say++; $display("FAIL tmo_fire: gecerli=%b hata=%b istek=%b veri=%h need 1/1/0/0",
                           v_gecerli, hata, b_istek, v_veri);
    end
    adim();
    kontrol_say++;
    if ({v_gecerli, hata} !== 2'b00) begin
      hata_say++; $display("FAIL tmo_pulse_len: gecerli=%b hata=%b need 0/0", v_gecerli, hata);
    end
`else
    begin
      int kotu = -1;
      for (int i = 0; i < 100; i++) begin
        adim();
        if (kotu < 0 && (b_istek !== 1'b1 || hata !== 1'b0 || v_gecerli !== 1'b0)) kotu = i;
      end
      kontrol_say++;
      if (kotu >= 0) begin
        hata_say++; $display("FAIL tmo_wait_forever: broke at cycle %0d istek=%b hata=%b gecerli=%b",
                             kotu, b_istek, hata, v_gecerli);
      end
    end
    b_hazir = 1'b1; b_overi = 32'h7777_7777;
    adim();
    kontrol_say++;
    if (v_gecerli !== 1'b1 || v_veri !== 32'h7777_7777) begin
      hata_say++; $display("FAIL tmo_late_done: gecerli=%b veri=%h need 1/77777777", v_gecerli, v_veri);
    end
    b_hazir = 1'b0;
    adim();
`endif
  endtask

  task automatic test_reset_mid();
    g_istek = 1'b1; g_adres = 32'h80; b_hazir = 1'b0;
    adim();
    kontrol_say++;
    if (g_kabul !== 1'b1) begin
      hata_say++; $display("FAIL rmid_kabul: got %b need 1", g_kabul);
    end
    g_istek = 1'b0;
    adim();
    #1 reset = 1'b0;
    #1;
    kontrol_say++;
    if ({b_istek, g_gecerli} !== 2'b00) begin
      hata_say++; $display("FAIL rmid_async: b_istek=%b gecerli=%b need 0/0", b_istek, g_gecerli);
    end
    adim();
    reset = 1'b1;
    adim();
    kontrol_say++;
    if ({b_istek, g_gecerli, v_gecerli} !== 3'b000) begin
      hata_say++; $display("FAIL rmid_quiet: b_istek=%b gecerli g/v=%b%b need 000",
                           b_istek, g_gecerli, v_gecerli);
    end
    g_istek = 1'b1; g_adres = 32'h84; v_istek = 1'b1; v_yaz = 1'b0; v_adres = 32'h300;
    adim();
    kontrol_say++;
    if ({g_kabul, v_kabul, b_adres} !== {1'b1, 1'b0, 32'h84}) begin
      hata_say++; $display("FAIL rmid_contention: kabul g/v=%b%b adres=%h need 10/84",
                           g_kabul, v_kabul, b_adres);
    end
    g_istek = 1'b0; v_istek = 1'b0; b_hazir = 1'b1;
    adim();
    b_hazir = 1'b0;
    adim();
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_single_fetch();
    test_store();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", hata_say, kontrol_say);
    $finish;
  end

endmodule
